regbus_responder: RTL

- Bus-side responder for the ALU core's 4-bit BUSREQ interface. It answers operand-index requests, register-read requests and result write-back requests.
- Holds a 16-entry register file and a small operand-index queue loaded by the host/test side.
- In the system it sits between the ALU core's request outputs and its operand/data inputs. It replaces the behavioural responder the bench currently emulates.

---
 rtl/regbus_pkg.sv | 19 +
 rtl/regbus_if.sv | 24 ++
 rtl/regbus_responder_opnd_fifo.sv | 63 ++++++
 rtl/regbus_responder.sv | 121 ++++++++++++
 4 files changed

// File: rtl/regbus_pkg.sv
// Shared types for the ALU core's BUSREQ responder: request codes and responder FSM states.
package regbus_pkg;

    localparam int unsigned IDX_W = 4;

    typedef enum logic [3:0] {
        REQ_IDLE  = 4'b0000,
        REQ_READ  = 4'b0001,
        REQ_WRITE = 4'b0010,
        REQ_NEXT  = 4'b0011
    } busreq_e;

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        HOLD
    } rsp_state_e;

endpackage

// File: rtl/regbus_if.sv
// Request/response bundle between the ALU core (master) and the regbus responder (slave).
interface regbus_if #(
    parameter int unsigned DATA_W = 8
);
    import regbus_pkg::*;

    logic [IDX_W-1:0]  busreq;
    logic [DATA_W-1:0] wr_data;
    logic [IDX_W-1:0]  opnd_idx;
    logic [DATA_W-1:0] rd_data;
    logic              rsp_valid;
    logic              rsp_err;

    modport master (
        output busreq, wr_data,
        input  opnd_idx, rd_data, rsp_valid, rsp_err
    );

    modport slave (
        input  busreq, wr_data,
        output opnd_idx, rd_data, rsp_valid, rsp_err
    );

endinterface

// File: rtl/regbus_responder_opnd_fifo.sv
// Operand-index FIFO; a push into a full queue is accepted only when a pop frees a slot that cycle.
module opnd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign full  = (count_q == (PW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + (PW+1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/regbus_responder.sv
// Answers the core's NEXT_OPND / READ_REG / WRITE_REG requests from an operand queue and a
// host-loadable register file; one RESP cycle performs the action, HOLD freezes the response.
module regbus_responder
    import regbus_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NREGS  = 16,
    parameter int unsigned QDEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    regbus_if.slave           bus,
    input  logic              q_push,
    input  logic [IDX_W-1:0]  q_idx,
    output logic              q_full,
    output logic              q_empty,
    input  logic              h_we,
    input  logic [IDX_W-1:0]  h_addr,
    input  logic [DATA_W-1:0] h_wdata
);
    rsp_state_e        state_q, state_d;
    logic [IDX_W-1:0]  req_q, req_d;
    logic [IDX_W-1:0]  opnd_q, opnd_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic              pop;
    logic [IDX_W-1:0]  head;

    opnd_fifo #(
        .DEPTH (QDEPTH),
        .W     (IDX_W)
    ) u_opnd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (q_push),
        .din   (q_idx),
        .pop   (pop),
        .dout  (head),
        .full  (q_full),
        .empty (q_empty)
    );

    assign bus.opnd_idx  = opnd_q;
    assign bus.rd_data   = rd_q;
    assign bus.rsp_valid = (state_q == HOLD);
    assign bus.rsp_err   = err_q;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        opnd_d  = opnd_q;
        rd_d    = rd_q;
        err_d   = err_q;
        pop     = 1'b0;
        regs_d  = regs_q;
        // Host write lands first so a same-cycle core write-back overrides it.
        if (h_we) begin
            regs_d[h_addr] = h_wdata;
        end
        unique case (state_q)
            IDLE: begin
                if (bus.busreq != REQ_IDLE) begin
                    req_d   = bus.busreq;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = HOLD;
                err_d   = 1'b0;
                case (req_q)
                    REQ_NEXT: begin
                        if (q_empty) begin
                            err_d = 1'b1;
                        end else begin
                            pop    = 1'b1;
                            opnd_d = head;
                        end
                    end
                    REQ_READ:  rd_d = regs_q[opnd_q];
                    REQ_WRITE: begin
                        regs_d[opnd_q] = bus.wr_data;
                        rd_d           = bus.wr_data;
                    end
                    default:   err_d = 1'b1;
                endcase
            end
            HOLD: begin
                if (bus.busreq == REQ_IDLE) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end else if (bus.busreq != req_q) begin
                    req_d   = bus.busreq;
                    state_d = RESP;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= '0;
            opnd_q  <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
            regs_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            opnd_q  <= opnd_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            regs_q  <= regs_d;
        end
    end

endmodule
